// File: rtl/rv32_bus_arbiter_if.sv
// rtl/rv32_bus_arbiter_if.sv - fetch, load/store and shared memory bus signals for rv32_bus_arbiter
interface rv32_bus_arbiter_if;
    logic [31:0] instr_address_in;
    logic        instr_read_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;
    logic [31:0] data_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] data_read_value_out;
    logic        data_ready_out;
    logic [31:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;
    logic        ready_in;
    logic        bus_error_out;

    // Arbiter side.
    modport slave (
        input  instr_address_in, instr_read_in,
        input  data_address_in, data_read_in, data_write_in,
        input  data_write_mask_in, data_write_value_in,
        input  read_value_in, ready_in,
        output instr_read_value_out, instr_ready_out,
        output data_read_value_out, data_ready_out,
        output address_out, read_out, write_out, write_mask_out, write_value_out,
        output bus_error_out
    );

    // Requester and memory side.
    modport master (
        output instr_address_in, instr_read_in,
        output data_address_in, data_read_in, data_write_in,
        output data_write_mask_in, data_write_value_in,
        output read_value_in, ready_in,
        input  instr_read_value_out, instr_ready_out,
        input  data_read_value_out, data_ready_out,
        input  address_out, read_out, write_out, write_mask_out, write_value_out,
        input  bus_error_out
    );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// rtl/rv32_bus_arbiter.sv - shares one memory bus between fetch and load/store ports with timeout abort
// Optional round-robin between the two ports: RV32_BUS_ARBITER_FAIR_EN.
module rv32_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    rv32_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t state;
    state_t state_next;
    logic   data_req;
    logic   prefer_instr;
    logic   timeout_hit;

    assign data_req = bus.data_read_in | bus.data_write_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            logic [CW-1:0] wait_count;

            // Cleared while idle, so every grant starts counting from zero.
            always_ff @(posedge clk) begin
                if (reset || state == IDLE) begin
                    wait_count <= '0;
                end else if (!bus.ready_in) begin
                    wait_count <= wait_count + 1'b1;
                end
            end

            assign timeout_hit = (state != IDLE) && !bus.ready_in &&
                                 (wait_count == CW'(TIMEOUT_CYCLES));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

`ifdef RV32_BUS_ARBITER_FAIR_EN
    logic last_was_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_was_data <= 1'b0;
        end else if (bus.data_ready_out) begin
            last_was_data <= 1'b1;
        end else if (bus.instr_ready_out) begin
            last_was_data <= 1'b0;
        end
    end

    assign prefer_instr = last_was_data;
`else
    assign prefer_instr = 1'b0;
`endif

    always_comb begin
        state_next               = state;
        bus.address_out          = 32'h0;
        bus.read_out             = 1'b0;
        bus.write_out            = 1'b0;
        bus.write_mask_out       = 4'h0;
        bus.write_value_out      = 32'h0;
        bus.instr_ready_out      = 1'b0;
        bus.instr_read_value_out = 32'h0;
        bus.data_ready_out       = 1'b0;
        bus.data_read_value_out  = 32'h0;
        bus.bus_error_out        = 1'b0;

        unique case (state)
            IDLE: begin
                if (data_req && !(bus.instr_read_in && prefer_instr)) begin
                    state_next = GRANT_DATA;
                end else if (bus.instr_read_in) begin
                    state_next = GRANT_INSTR;
                end
            end

            GRANT_INSTR: begin
                bus.address_out          = bus.instr_address_in;
                bus.instr_read_value_out = timeout_hit ? 32'h0 : bus.read_value_in;
                // A dropped request is a pipeline flush: release the bus silently.
                if (!bus.instr_read_in) begin
                    state_next = IDLE;
                end else if (bus.ready_in) begin
                    bus.read_out        = 1'b1;
                    bus.instr_ready_out = 1'b1;
                    state_next          = IDLE;
                end else if (timeout_hit) begin
                    bus.instr_ready_out = 1'b1;
                    bus.bus_error_out   = 1'b1;
                    state_next          = IDLE;
                end else begin
                    bus.read_out = 1'b1;
                end
            end

            GRANT_DATA: begin
                bus.address_out         = bus.data_address_in;
                bus.write_mask_out      = bus.data_write_mask_in;
                bus.write_value_out     = bus.data_write_value_in;
                bus.data_read_value_out = timeout_hit ? 32'h0 : bus.read_value_in;
                if (!data_req) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    bus.data_ready_out = 1'b1;
                    bus.bus_error_out  = 1'b1;
                    state_next         = IDLE;
                end else begin
                    bus.read_out       = bus.data_read_in;
                    bus.write_out      = bus.data_write_in;
                    bus.data_ready_out = bus.ready_in;
                    if (bus.ready_in) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule
